// File: rtl/fila_pkg.sv
// Shared types and constants for the fila_entrada word queue.
package fila_pkg;

  // Enqueue handshake states: capture, acknowledge, wait for release
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RELEASE = 2'd2
  } fila_state_t;

  localparam int FILA_WIDTH  = 8;
  localparam int FILA_DEPTH  = 8;
  localparam int STALL_LIMIT = 16;

endpackage

// File: rtl/fila_mem.sv
// DEPTH x WIDTH storage array for fila_entrada with one write port and a
// registered read port. Contents are not reset; only the read register is.
module fila_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write; no reset because stale contents are never read
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read; holds the last popped word until the next pop
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_q[raddr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/fila_entrada.sv
// fila_entrada: word queue sitting right after the deserializer.
// Captures a word offered on enqueue_in, answers with a one-cycle ack_out,
// then waits for enqueue_in to drop before it can capture again. While the
// queue is full the word is simply not acked, which holds the deserializer.
// Optional build macro FILA_ENTRADA_ERR_EN adds a sticky err_out flag
// (pop on empty, or an enqueue stalled on full for STALL_LIMIT cycles).
module fila_entrada
  import fila_pkg::*;
#(
  parameter int WIDTH = FILA_WIDTH,
  parameter int DEPTH = FILA_DEPTH
) (
  input  logic                   clock_100KHz,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   enqueue_in,
  output logic                   ack_out,
  input  logic                   dequeue_in,
  output logic [WIDTH-1:0]       data_out,
  output logic [$clog2(DEPTH):0] len_out
`ifdef FILA_ENTRADA_ERR_EN
  ,
  output logic                   err_out
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  fila_state_t   state_q;
  logic          ack_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] len_q, len_d;
  logic          full_s;
  logic          empty_s;
  logic          wr_en_s;
  logic          rd_en_s;

  // Full/empty use start-of-cycle occupancy, so a pop never frees space
  // for a capture in the same cycle and vice versa.
  assign full_s  = (len_q == LW'(DEPTH));
  assign empty_s = (len_q == LW'(0));
  assign wr_en_s = (state_q == IDLE) && enqueue_in && !full_s;
  assign rd_en_s = dequeue_in && !empty_s;

  // Enqueue handshake FSM with registered acknowledge
  always_ff @(posedge clock_100KHz) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_en_s) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end
        end
        ACK: begin
          state_q <= RELEASE;
          ack_q   <= 1'b0;
        end
        RELEASE: begin
          ack_q <= 1'b0;
          if (!enqueue_in) begin
            state_q <= IDLE;
          end else begin
            state_q <= RELEASE;
          end
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  // Next-state for pointers and occupancy counter
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   len_d = len_q + LW'(1);
      2'b01:   len_d = len_q - LW'(1);
      default: len_d = len_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock_100KHz) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
    end
  end

  fila_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clock_100KHz),
    .reset (reset),
    .we    (wr_en_s),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (rd_en_s),
    .raddr (rd_ptr_q),
    .rdata (data_out)
  );

  assign ack_out = ack_q;
  assign len_out = len_q;

`ifdef FILA_ENTRADA_ERR_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);

  logic [SW-1:0] stall_q, stall_d;
  logic          err_q, err_d;
  logic          stall_s;

  assign stall_s = (state_q == IDLE) && enqueue_in && full_s;

  // Stall counter and sticky error next-state
  always_comb begin
    stall_d = stall_q;
    err_d   = err_q;
    if (stall_s) begin
      if (stall_q == SW'(STALL_LIMIT)) begin
        stall_d = stall_q;
      end else begin
        stall_d = stall_q + SW'(1);
      end
    end else begin
      stall_d = '0;
    end
    if ((dequeue_in && empty_s) ||
        (stall_s && (stall_q == SW'(STALL_LIMIT - 1)))) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Stall counter and sticky error registers
  always_ff @(posedge clock_100KHz) begin
    if (reset) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err_out = err_q;
`endif

endmodule

// File: tb/tb_fila_entrada.sv
// Scoreboard bench for fila_entrada: stimulus pushes the hand-computed word
// expected for every dequeue request; a monitor pops and compares data_out
// one step after each clock edge on which dequeue_in was high.
module tb_fila_entrada;

  logic       clock_100KHz;
  logic       reset;
  logic [7:0] data_in;
  logic       enqueue_in;
  logic       ack_out;
  logic       dequeue_in;
  logic [7:0] data_out;
  logic [3:0] len_out;
`ifdef FILA_ENTRADA_ERR_EN
  logic       err_out;
`endif

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q [$];

  fila_entrada #(.WIDTH(8), .DEPTH(8)) dut (
    .clock_100KHz (clock_100KHz),
    .reset        (reset),
    .data_in      (data_in),
    .enqueue_in   (enqueue_in),
    .ack_out      (ack_out),
    .dequeue_in   (dequeue_in),
    .data_out     (data_out),
    .len_out      (len_out)
`ifdef FILA_ENTRADA_ERR_EN
    ,
    .err_out      (err_out)
`endif
  );

  initial clock_100KHz = 1'b0;
  always #5 clock_100KHz = ~clock_100KHz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted dequeue request is followed by a data_out check
  always @(posedge clock_100KHz) begin
    if (dequeue_in === 1'b1 && reset === 1'b0) begin
      #1;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_underflow: got %0h expected none", data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          n_bad++;
          $display("FAIL sb_data: got %0h expected %0h", data_out, e);
        end
      end
    end
  end

  task automatic wait_ack(output int cyc);
    int c;
    c = 0;
    @(negedge clock_100KHz);
    while (ack_out !== 1'b1 && c < 20) begin
      @(negedge clock_100KHz);
      c++;
    end
    cyc = c;
  endtask

  task automatic push(input logic [7:0] w);
    int c;
    data_in    = w;
    enqueue_in = 1'b1;
    wait_ack(c);
    chk("push_ack", 32'(ack_out), 32'd1);
    enqueue_in = 1'b0;
    @(negedge clock_100KHz);
    chk("ack_pulse_end", 32'(ack_out), 32'd0);
    @(negedge clock_100KHz);
  endtask

  task automatic pop(input logic [7:0] e);
    dequeue_in = 1'b1;
    exp_q.push_back(e);
    @(negedge clock_100KHz);
    dequeue_in = 1'b0;
  endtask

  initial begin
    int c;
    int acks;
    logic acc;
    reset      = 1'b1;
    data_in    = 8'h00;
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    repeat (2) @(negedge clock_100KHz);
    chk("rst_len", 32'(len_out), 32'd0);
    chk("rst_ack", 32'(ack_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
`ifdef FILA_ENTRADA_ERR_EN
    chk("rst_err", 32'(err_out), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clock_100KHz);

    // Single word: ack visible in the cycle right after the capture edge
    data_in    = 8'h41;
    enqueue_in = 1'b1;
    wait_ack(c);
    chk("single_ack_latency", 32'(c), 32'd0);
    chk("single_ack", 32'(ack_out), 32'd1);
    enqueue_in = 1'b0;
    @(negedge clock_100KHz);
    chk("single_ack_one_cycle", 32'(ack_out), 32'd0);
    chk("single_len", 32'(len_out), 32'd1);
    @(negedge clock_100KHz);
    pop(8'h41);
    chk("single_len_after_pop", 32'(len_out), 32'd0);

    // Fill to full, then backpressure on a ninth word
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("full_len", 32'(len_out), 32'd8);
    data_in    = 8'h09;
    enqueue_in = 1'b1;
    acc        = 1'b0;
    repeat (4) begin
      @(negedge clock_100KHz);
      acc = acc | ack_out;
    end
    chk("full_backpressure", 32'(acc), 32'd0);
    chk("full_len_hold", 32'(len_out), 32'd8);
    pop(8'h01);
    chk("full_len_after_pop", 32'(len_out), 32'd7);
    wait_ack(c);
    chk("full_retry_ack", 32'(ack_out), 32'd1);
    chk("full_retry_latency", 32'(c), 32'd0);
    enqueue_in = 1'b0;
    repeat (2) @(negedge clock_100KHz);
    chk("full_len_refill", 32'(len_out), 32'd8);
    for (int i = 2; i <= 9; i++) pop(8'(i));
    chk("drain_len", 32'(len_out), 32'd0);

    // Wrap-around of both pointers
    for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i));
    for (int i = 0; i < 5; i++) pop(8'hB0 + 8'(i));
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    chk("wrap_len_full", 32'(len_out), 32'd8);
    for (int i = 0; i < 8; i++) pop(8'hA0 + 8'(i));
    chk("wrap_len_empty", 32'(len_out), 32'd0);

    // Capture and pop on the same edge: occupancy unchanged, oldest popped
    push(8'h11);
    push(8'h22);
    push(8'h33);
    data_in    = 8'h55;
    enqueue_in = 1'b1;
    dequeue_in = 1'b1;
    exp_q.push_back(8'h11);
    @(negedge clock_100KHz);
    dequeue_in = 1'b0;
    chk("simul_len", 32'(len_out), 32'd3);
    chk("simul_ack", 32'(ack_out), 32'd1);
    enqueue_in = 1'b0;
    repeat (2) @(negedge clock_100KHz);
    pop(8'h22);
    pop(8'h33);
    pop(8'h55);
    chk("simul_len_drain", 32'(len_out), 32'd0);

    // Held enqueue_in: one write and one ack only
    data_in    = 8'h77;
    enqueue_in = 1'b1;
    acks       = 0;
    repeat (6) begin
      @(negedge clock_100KHz);
      acks += int'(ack_out);
    end
    enqueue_in = 1'b0;
    repeat (2) @(negedge clock_100KHz);
    chk("held_ack_count", 32'(acks), 32'd1);
    chk("held_len", 32'(len_out), 32'd1);
    pop(8'h77);
    chk("held_len_pop", 32'(len_out), 32'd0);

    // Pop on empty: ignored, data_out holds the last popped word
    pop(8'h77);
    chk("empty_pop_len", 32'(len_out), 32'd0);
`ifdef FILA_ENTRADA_ERR_EN
    chk("err_set", 32'(err_out), 32'd1);
    repeat (3) @(negedge clock_100KHz);
    chk("err_sticky", 32'(err_out), 32'd1);
`endif

    // Reset during ACK aborts the handshake
    data_in    = 8'h99;
    enqueue_in = 1'b1;
    @(negedge clock_100KHz);
    chk("mid_ack_before_rst", 32'(ack_out), 32'd1);
    reset = 1'b1;
    @(negedge clock_100KHz);
    chk("mid_rst_ack", 32'(ack_out), 32'd0);
    chk("mid_rst_len", 32'(len_out), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
`ifdef FILA_ENTRADA_ERR_EN
    chk("mid_rst_err", 32'(err_out), 32'd0);
`endif
    reset      = 1'b0;
    enqueue_in = 1'b0;
    @(negedge clock_100KHz);
    push(8'hC3);
    chk("post_rst_len", 32'(len_out), 32'd1);
    pop(8'hC3);
    @(negedge clock_100KHz);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time bound in case a handshake never completes
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/fila_entrada.md
Name: fila_entrada

Overview:
- Word queue directly downstream of the deserializer.
- Accepts 8-bit words offered with the deserializer's data_ready and returns the one-cycle acknowledge it waits for (deserializer ack_in).
- Buffers up to DEPTH words and hands them to the consumer on dequeue_in, oldest first.
- Backpressure: while full it withholds the acknowledge, which keeps the deserializer holding its word.

Parameters:
- WIDTH, 8, word width in bits.
- DEPTH, 8, number of entries; power of two, at least 2.

Ports:
- clock_100KHz  in  1  single clock for all state.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock_100KHz.
- data_in  in  WIDTH  word from the deserializer's data_out.
- enqueue_in  in  1  connected to the deserializer's data_ready; high means data_in is valid.
- ack_out  out  1  connected to the deserializer's ack_in; one-cycle pulse after a word is stored.
- dequeue_in  in  1  consumer request to pop the head word.
- data_out  out  WIDTH  last popped word, registered.
- len_out  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (synchronous): ack_out=0, data_out=0, len_out=0, rd/wr pointers=0, FSM=IDLE. Storage contents are don't-care.
- Reset asserted mid-handshake aborts it. Any word not yet acked is not stored, and ack_out is 0 the cycle after reset.
- Enqueue FSM has three states: IDLE, ACK, RELEASE.
  - IDLE: if enqueue_in=1 and len<DEPTH, write data_in at wr_ptr, increment wr_ptr, go to ACK.
  - IDLE: if enqueue_in=1 and len=DEPTH, stay in IDLE with ack_out=0 (backpressure); retry every cycle.
  - ACK: ack_out=1 for exactly this cycle; next state RELEASE.
  - RELEASE: ack_out=0; wait for enqueue_in=0, then go to IDLE. This prevents a second capture of the same word.
- Full check: uses len at the start of the cycle. A same-cycle dequeue does not free space for an enqueue in that cycle.
- Enqueue latency: word stored at edge N, ack_out high during cycle N+1, earliest next capture at edge N+3.
- Dequeue:
  - dequeue_in=1 and len>0: data_out <= mem[rd_ptr], rd_ptr increments; data_out is valid the cycle after the request.
  - dequeue_in=1 and len=0: ignored; data_out holds, pointers unchanged.
  - dequeue_in is level-sensitive: held high, it pops one word per cycle.
- Simultaneous enqueue write and dequeue in the same cycle: both take effect and len is unchanged.
  - When len=0, the dequeue is ignored (empty check uses start-of-cycle len) and len becomes 1.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- len_out is a separate counter: +1 on write only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH or goes below 0.

Optional Feature:
- Macro: FILA_ENTRADA_ERR_EN.
- Defined: adds output err_out (1 bit), reset 0. It sets sticky on dequeue_in with len=0, or enqueue_in held in IDLE at len=DEPTH for 16 consecutive cycles (stall counter). It clears only on reset.
- Undefined: no err_out port, no stall counter; behaviour otherwise identical.

Decomposition:
- Package fila_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACK, RELEASE} fila_state_t
  - default constants FILA_WIDTH=8, FILA_DEPTH=8
  - STALL_LIMIT=16
- Sub-module fila_mem: a DEPTH x WIDTH register array with write port (we, waddr, wdata) and registered read port (re, raddr, rdata); no reset on contents.
- FSM, pointers, len counter and error logic stay in fila_entrada.

Test Plan:
- Reset then single word: enqueue_in=1 with data_in=8'h41 → ack_out high exactly one cycle, one cycle after capture; len_out=1. Then dequeue_in one cycle → data_out=8'h41 next cycle; len_out=0.
- Fill to full: 8 words 8'h01..8'h08 via handshakes → len_out=8. A 9th offer (8'h09) held high → ack_out stays 0. One dequeue → data_out=8'h01; 8'h09 is then acked; len_out=8.
- Wrap-around: push 5, pop 5, push 8'hA0..8'hA7, pop 8 → data_out sequence A0..A7 in order; len_out returns to 0.
- Simultaneous: len=3; same cycle as a capture of 8'h55, assert dequeue → len_out stays 3; popped word is the oldest entry, not 8'h55.
- Held enqueue_in: keep enqueue_in=1 for 6 cycles with one word → exactly one write, one ack pulse, len_out=1.
- Reset mid-handshake: assert reset during ACK → ack_out=0 and len_out=0 next cycle. With FILA_ENTRADA_ERR_EN: a pop on empty sets err_out=1, which stays 1 until reset.
